// File: rtl/i2s_source_core.sv
// I2S transmitter: 64-bit-period frames, left/right word fetch at each slot start.
// Optional macro I2S_SOURCE_UNDERFLOW_CNT_EN enables the saturating underflow counter.
`timescale 1ns/1ps
module i2s_source_core #(
   parameter int unsigned WIDTH = 24
) (
   input  logic             i2s_master_clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [9:0]       clk_divide_ratio,
   input  logic [WIDTH-1:0] samples_data,
   input  logic             samples_valid,
   output logic             samples_ready,
   output logic             bck,
   output logic             lrck,
   output logic             sdata,
   output logic [15:0]      underflow_count
);

   localparam int unsigned P_W   = 4;
   localparam int unsigned B_W   = 6;
   localparam int unsigned CNT_W = 16;

   logic [P_W-1:0] p_q, p_d;
   logic [P_W-1:0] n_q, n_d, n_in;
   logic [B_W-1:0] b_q, b_d;
   logic [31:0]    word_q, word_d;
   logic [4:0]     s;
   logic           fetch_c;
   logic           in_word_c;
   logic           ratio_unused;

   assign ratio_unused = ^clk_divide_ratio[5:0];
   assign n_in = (clk_divide_ratio[9:6] < 4'd2) ? P_W'(2) : clk_divide_ratio[9:6];
   assign s    = b_q[4:0];

   // Fetch happens on the first phase of each slot (b = 0 or 32)
   assign fetch_c   = enable && !reset && (p_q == '0) && (s == '0);
   assign in_word_c = (s != '0) && (32'(s) <= WIDTH);

   assign samples_ready = fetch_c;
   assign bck   = enable && (p_q >= (n_q >> 1));
   assign lrck  = enable && b_q[5];
   assign sdata = enable && in_word_c && word_q[5'(WIDTH - 32'(s))];

   always_ff @(posedge i2s_master_clk or posedge reset) begin
      if (reset) begin
         p_q    <= '0;
         b_q    <= '0;
         n_q    <= P_W'(2);
         word_q <= '0;
      end else begin
         p_q    <= p_d;
         b_q    <= b_d;
         n_q    <= n_d;
         word_q <= word_d;
      end
   end

   // Phase/bit counters, bit-period latch and word capture
   always_comb begin
      p_d    = p_q;
      b_d    = b_q;
      n_d    = n_q;
      word_d = word_q;
      if (!enable) begin
         p_d = '0;
         b_d = '0;
      end else begin
         if ((p_q == '0) && (b_q == '0))
            n_d = n_in;
         if (fetch_c)
            word_d = samples_valid ? 32'(samples_data) : '0;
         if (p_q == n_q - P_W'(1)) begin
            p_d = '0;
            b_d = b_q + B_W'(1);
         end else begin
            p_d = p_q + P_W'(1);
         end
      end
   end

`ifdef I2S_SOURCE_UNDERFLOW_CNT_EN
   logic [CNT_W-1:0] uf_q;

   always_ff @(posedge i2s_master_clk or posedge reset) begin
      if (reset)
         uf_q <= '0;
      else if (fetch_c && !samples_valid && (uf_q != '1))
         uf_q <= uf_q + CNT_W'(1);
   end

   assign underflow_count = uf_q;
`else
   assign underflow_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_i2s_source_core.sv
// Directed bench for i2s_source_core: frame timing, slot data, underflow, ratio latch, enable abort.
`timescale 1ns/1ps
module tb_i2s_source_core;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [9:0]  clk_divide_ratio;
   logic [23:0] samples_data;
   logic        samples_valid;
   logic        samples_ready;
   logic        bck;
   logic        lrck;
   logic        sdata;
   logic [15:0] underflow_count;

   int total = 0;
   int bad   = 0;
   int uf_exp = 0;
   logic [23:0] rxl, rxr;

   i2s_source_core #(.WIDTH(24)) dut (
      .i2s_master_clk  (clk),
      .reset           (reset),
      .enable          (enable),
      .clk_divide_ratio(clk_divide_ratio),
      .samples_data    (samples_data),
      .samples_valid   (samples_valid),
      .samples_ready   (samples_ready),
      .bck             (bck),
      .lrck            (lrck),
      .sdata           (sdata),
      .underflow_count (underflow_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Walks one frame from (b=0,p=0); returns early at p=0 of stop_b.
   task automatic run_frame(input int n, input logic [23:0] l, input logic [23:0] r,
                            input logic vl, input logic vr, input int stop_b,
                            input logic [9:0] ratio_after,
                            output logic [23:0] ol, output logic [23:0] orr);
      logic [23:0] w;
      logic [3:0]  exp;
      int s;
      ol = '0;
      orr = '0;
      for (int b = 0; b < 64; b++) begin
         for (int p = 0; p < n; p++) begin
            if (b == stop_b) return;
            if (b == 10 && p == 0) clk_divide_ratio = ratio_after;
            samples_data  = (b < 32) ? l : r;
            samples_valid = (b < 32) ? vl : vr;
            w = (b < 32) ? (vl ? l : 24'h0) : (vr ? r : 24'h0);
            s = b % 32;
            exp = {(p >= n / 2), (b >= 32), (p == 0 && s == 0),
                   ((s >= 1 && s <= 24) ? w[24 - s] : 1'b0)};
            check($sformatf("cyc n%0d b%0d p%0d bck/lrck/rdy/sd", n, b, p),
                  32'({bck, lrck, samples_ready, sdata}), 32'(exp));
            if (p == n / 2 && s >= 1 && s <= 24) begin
               if (b < 32) ol[24 - s] = sdata;
               else        orr[24 - s] = sdata;
            end
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      clk_divide_ratio = 10'd512;
      samples_data = 24'hA5A5A5;
      samples_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", 32'({bck, lrck, samples_ready, sdata}), 32'h0);
      check("reset uf", 32'(underflow_count), 32'h0);

      reset = 1'b0;
      #1;
      check("first ready", 32'(samples_ready), 32'h1);

      // N=8 with both words valid
      run_frame(8, 24'hA5A5A5, 24'h123456, 1'b1, 1'b1, 64, 10'd512, rxl, rxr);
      check("rx left 512", 32'(rxl), 32'hA5A5A5);
      check("rx right 512", 32'(rxr), 32'h123456);

      // Ratio 512 -> 256 mid-frame: this frame stays N=8
      run_frame(8, 24'h800001, 24'h7FFFFE, 1'b1, 1'b1, 64, 10'd256, rxl, rxr);
      check("rx left midchg", 32'(rxl), 32'h800001);
      check("rx right midchg", 32'(rxr), 32'h7FFFFE);

      run_frame(4, 24'hFFFFFF, 24'h000001, 1'b1, 1'b1, 64, 10'd128, rxl, rxr);
      check("rx left n4", 32'(rxl), 32'hFFFFFF);
      check("rx right n4", 32'(rxr), 32'h000001);

      run_frame(2, 24'h5A5A5A, 24'hC3C3C3, 1'b1, 1'b1, 64, 10'd0, rxl, rxr);
      check("rx left n2", 32'(rxl), 32'h5A5A5A);
      check("rx right n2", 32'(rxr), 32'hC3C3C3);

      run_frame(2, 24'h0F0F0F, 24'hF0F0F0, 1'b1, 1'b1, 64, 10'd200, rxl, rxr);
      check("rx left ratio0", 32'(rxl), 32'h0F0F0F);
      check("rx right ratio0", 32'(rxr), 32'hF0F0F0);

      // N=3, right fetch underflows
      run_frame(3, 24'h13579B, 24'hFEDCBA, 1'b1, 1'b0, 64, 10'd200, rxl, rxr);
      check("rx left n3", 32'(rxl), 32'h13579B);
      check("rx right uf", 32'(rxr), 32'h0);
`ifdef I2S_SOURCE_UNDERFLOW_CNT_EN
      uf_exp = 1;
`endif
      check("uf after right drop", 32'(underflow_count), 32'(uf_exp));

      for (int f = 0; f < 3; f++) begin
         run_frame(3, 24'hABCDEF, 24'h654321, 1'b0, 1'b0, 64, 10'd200, rxl, rxr);
         check($sformatf("rx all-uf frame %0d", f), 32'({rxl, rxr[7:0]}), 32'h0);
      end
`ifdef I2S_SOURCE_UNDERFLOW_CNT_EN
      uf_exp = 7;
`endif
      check("uf after 3 frames", 32'(underflow_count), 32'(uf_exp));

      // Abort at b=40, then restart with a left fetch
      run_frame(3, 24'h111111, 24'h222222, 1'b1, 1'b1, 40, 10'd512, rxl, rxr);
      check("lrck before abort", 32'(lrck), 32'h1);
      enable = 1'b0;
      #1;
      check("abort outputs", 32'({bck, lrck, samples_ready, sdata}), 32'h0);
      repeat (5) begin
         @(posedge clk); #1;
         check("disabled outputs", 32'({bck, lrck, samples_ready, sdata}), 32'h0);
      end
      enable = 1'b1;
      #1;
      run_frame(8, 24'h333333, 24'h444444, 1'b1, 1'b1, 64, 10'd512, rxl, rxr);
      check("rx left restart", 32'(rxl), 32'h333333);
      check("rx right restart", 32'(rxr), 32'h444444);
      check("uf final", 32'(underflow_count), 32'(uf_exp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2s_source_core.md
I2S_SOURCE_CORE -- requirements
Module: i2s_source_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 24, meaning sample word width in bits (legal 1..31).
REQ-002 The block SHALL have port i2s_master_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port enable, input, 1 bit: run the I2S stream when high.
REQ-005 The block SHALL have port clk_divide_ratio, input, 10 bits: master-clock cycles per LRCK frame.
REQ-006 The block SHALL have port samples_data, input, WIDTH bits: sample word (two's complement), interleaved left then right.
REQ-007 The block SHALL have port samples_valid, input, 1 bit: samples_data is valid.
REQ-008 The block SHALL have port samples_ready, output, 1 bit: the block accepts a word in this cycle.
REQ-009 The block SHALL have port bck, output, 1 bit: I2S bit clock.
REQ-010 The block SHALL have port lrck, output, 1 bit: word select; 0 = left, 1 = right.
REQ-011 The block SHALL have port sdata, output, 1 bit: serial data.
REQ-012 The block SHALL have port underflow_count, output, 16 bits: see Configuration.

Function
REQ-013 Bit period and slots:
- Bit period N = clk_divide_ratio[9:6] cycles; N<2 SHALL be treated as 2; bits [5:0] are ignored.
- A frame SHALL be 64 bit periods: bit index b = 0..63, slot bit s = b[4:0].
REQ-014 Phase counter p SHALL count 0..N-1 within each bit period; bck SHALL be 0 for p < floor(N/2), else 1 (falling edge at p=0; receiver samples on rising edge).
REQ-015 At p=0 of bit b, lrck SHALL be set to b[5] and sdata SHALL be set to:
- word[WIDTH-s] for 1 <= s <= WIDTH;
- 0 otherwise.
This is standard I2S: MSB one bck after the lrck edge, zero padded.
REQ-016 Word fetch:
- samples_ready SHALL be asserted for exactly the one cycle at p=0 of b=0 (left) and b=32 (right).
- A word transfers when samples_valid is high in that cycle; the transferred word is the source for that slot.
REQ-017 Underflow: if samples_valid is low in a ready cycle, that slot SHALL transmit all zeros, and the block SHALL count one underflow.
REQ-018 Bit period latch: N SHALL be latched at p=0 of b=0. Changes to clk_divide_ratio mid-frame SHALL take effect at the next frame.
REQ-019 While enable is low:
- bck, lrck, sdata and samples_ready SHALL be 0;
- p and b SHALL be held at 0;
- no words SHALL be consumed.
REQ-020 On the first cycle with enable high, the block SHALL be at p=0, b=0, so the stream starts with the left slot and its fetch.
REQ-021 Enable deasserted mid-frame SHALL abort the frame immediately. The partially sent word SHALL be discarded, not re-sent.
REQ-022 Counter wrap: b SHALL wrap 63 -> 0 with no gap cycles, giving a continuous stream.

Reset
REQ-023 Reset asserted SHALL asynchronously clear all state; outputs SHALL be bck=0, lrck=0, sdata=0, samples_ready=0, underflow_count=0.
REQ-024 Reset released with enable high SHALL start at b=0, p=0 on the first clock edge.

Configuration
REQ-025 With macro I2S_SOURCE_UNDERFLOW_CNT_EN defined:
- underflow_count SHALL increment by one per underflowed slot, saturating at 65535;
- it SHALL be cleared only by reset.
REQ-026 Without the macro, underflow_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-027 Ratio 512, WIDTH=24, left 0xA5A5A5 and right 0x123456 always valid -> bck period 8 cycles (4 low, 4 high) and lrck period 512 cycles. Receiver captures bits 1..24 of each slot as the words and bits 25..31 and 0 as zeros.
REQ-028 Ratio 128 -> bck period 2 cycles (1 low, 1 high). Ratio 0 -> also period 2. Ratio 200 (N=3) -> 1 low, 2 high.
REQ-029 samples_valid tied low for 3 frames with the macro defined -> sdata constantly 0 and underflow_count=6. Without the macro -> underflow_count stays 0.
REQ-030 samples_ready pulses exactly twice per frame, at b=0 and b=32. Dropping valid for only the right-slot fetch -> right slot all zeros, left slot intact.
REQ-031 enable dropped at b=40 then raised -> outputs go 0 at once, and the next stream begins with a left fetch.
REQ-032 Ratio changed 512->256 mid-frame -> current frame finishes with N=8, next frame uses N=4.
